// File: rtl/mips_cpu_pkg.sv
// Shared types and constants for the MIPS multiply/divide unit.
package mips_cpu_pkg;

    // Operation selector driven by the instruction decoder.
    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } muldiv_op_t;

    // Divider sequencing states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        FIXUP  = 2'd2
    } muldiv_state_t;

    // LO value produced by a divide with a zero divisor.
    localparam logic [31:0] DIV_BY_ZERO_LO = 32'hFFFF_FFFF;

    // Two's complement magnitude of v when neg is set, otherwise v unchanged.
    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mips_cpu_div_step.sv
// One combinational restoring-division step.
// The partial remainder is shifted left taking in the next dividend bit
// (the MSB of the quotient register); if the divisor fits, it is subtracted
// and a 1 is shifted into the quotient register, otherwise a 0.
module mips_cpu_div_step (
    input  logic [31:0] i_rem,
    input  logic [31:0] i_quo,
    input  logic [31:0] i_divisor,
    output logic [31:0] o_rem,
    output logic [31:0] o_quo
);
    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic        w_fits;

    // The partial remainder always stays below the divisor, so the shifted
    // value fits in 33 bits and the restored remainder fits in 32.
    assign w_shift = {i_rem, i_quo[31]};
    assign w_diff  = w_shift - {1'b0, i_divisor};
    assign w_fits  = ~w_diff[32];
    assign o_rem   = w_fits ? w_diff[31:0] : w_shift[31:0];
    assign o_quo   = {i_quo[30:0], w_fits};

endmodule

// File: rtl/mips_cpu_muldiv.sv
// Multiply/divide unit holding the architectural HI/LO registers.
// Multiplies and HI/LO moves complete at the accepting edge; divides run an
// iterative restoring divider while o_busy stalls the controller.
//
// Handshake: i_start is a request qualified by i_op/i_operand_a/i_operand_b.
// It is accepted on the rising edge where i_start && i_clk_enable && !o_busy;
// a request seen while o_busy is high is dropped with no effect, so the
// requester must keep i_start and its operands stable until o_busy is low.
// o_done pulses for one enabled cycle after an arithmetic op updates HI/LO.
module mips_cpu_muldiv
    import mips_cpu_pkg::*;
#(
    parameter int DIV_STEPS_PER_CYCLE = 1
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_clk_enable,
    input  logic          i_start,
    input  muldiv_op_t    i_op,
    input  logic [31:0]   i_operand_a,
    input  logic [31:0]   i_operand_b,
    output logic          o_busy,
    output logic          o_done,
    output logic [31:0]   o_hi,
    output logic [31:0]   o_lo,
    output muldiv_state_t o_state
);
    localparam int         DIV_CYCLES = 32 / DIV_STEPS_PER_CYCLE;
    localparam logic [4:0] LAST_COUNT = 5'(DIV_CYCLES - 1);

    muldiv_state_t r_state;
    muldiv_state_t w_state_next;
    logic [4:0]    r_count;
    logic          r_busy;
    logic          r_done;
    logic [31:0]   r_hi;
    logic [31:0]   r_lo;
    logic [31:0]   r_rem;
    logic [31:0]   r_quo;
    logic [31:0]   r_divisor;
    logic          r_neg_q;
    logic          r_neg_r;
    logic          r_div_zero;

    logic          w_accept;
    logic          w_is_div;
    logic          w_signed_div;
    logic [63:0]   w_prod_s;
    logic [63:0]   w_prod_u;
    logic [31:0]   w_mag_a;
    logic [31:0]   w_mag_b;
    logic [31:0]   w_quo_fix;
    logic [31:0]   w_rem_fix;
    logic [31:0]   w_rem_chain [0:DIV_STEPS_PER_CYCLE];
    logic [31:0]   w_quo_chain [0:DIV_STEPS_PER_CYCLE];

    assign w_accept     = i_start && i_clk_enable && !r_busy;
    assign w_is_div     = (i_op == OP_DIV) || (i_op == OP_DIVU);
    assign w_signed_div = (i_op == OP_DIV);

    // Low 64 bits of the product of sign-extended operands give the signed product.
    assign w_prod_s = {{32{i_operand_a[31]}}, i_operand_a} * {{32{i_operand_b[31]}}, i_operand_b};
    assign w_prod_u = {32'd0, i_operand_a} * {32'd0, i_operand_b};

    assign w_mag_a = magnitude(i_operand_a, w_signed_div && i_operand_a[31]);
    assign w_mag_b = magnitude(i_operand_b, w_signed_div && i_operand_b[31]);

    // Sign fix-up: quotient truncates toward zero, remainder follows the dividend.
    // A zero divisor leaves the dividend in the remainder, so HI ends up equal to operand_a.
    assign w_quo_fix = magnitude(r_quo, r_neg_q);
    assign w_rem_fix = magnitude(r_rem, r_neg_r);

    // Chain of restoring steps resolving DIV_STEPS_PER_CYCLE bits per cycle.
    assign w_rem_chain[0] = r_rem;
    assign w_quo_chain[0] = r_quo;
    for (genvar g = 0; g < DIV_STEPS_PER_CYCLE; g++) begin : g_step
        mips_cpu_div_step u_step (
            .i_rem     (w_rem_chain[g]),
            .i_quo     (w_quo_chain[g]),
            .i_divisor (r_divisor),
            .o_rem     (w_rem_chain[g+1]),
            .o_quo     (w_quo_chain[g+1])
        );
    end

    // Next-state decode for the divider sequencer.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept && w_is_div) w_state_next = DIVIDE;
            DIVIDE:  if (r_count == LAST_COUNT) w_state_next = FIXUP;
            FIXUP:   w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // State register and registered busy flag, frozen while the pipeline stalls.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
        end else if (i_clk_enable) begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next != IDLE);
        end
    end

    // HI/LO, divider datapath, iteration counter and done pulse.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count    <= 5'd0;
            r_done     <= 1'b0;
            r_hi       <= 32'd0;
            r_lo       <= 32'd0;
            r_rem      <= 32'd0;
            r_quo      <= 32'd0;
            r_divisor  <= 32'd0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
        end else if (i_clk_enable) begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        case (i_op)
                            OP_MULT: begin
                                {r_hi, r_lo} <= w_prod_s;
                                r_done       <= 1'b1;
                            end
                            OP_MULTU: begin
                                {r_hi, r_lo} <= w_prod_u;
                                r_done       <= 1'b1;
                            end
                            OP_DIV, OP_DIVU: begin
                                r_rem      <= 32'd0;
                                r_quo      <= w_mag_a;
                                r_divisor  <= w_mag_b;
                                r_neg_q    <= w_signed_div && (i_operand_a[31] ^ i_operand_b[31]);
                                r_neg_r    <= w_signed_div && i_operand_a[31];
                                r_div_zero <= (i_operand_b == 32'd0);
                                r_count    <= 5'd0;
                            end
                            OP_MTHI: r_hi <= i_operand_a;
                            OP_MTLO: r_lo <= i_operand_a;
                            default: ;
                        endcase
                    end
                end
                DIVIDE: begin
                    r_rem   <= w_rem_chain[DIV_STEPS_PER_CYCLE];
                    r_quo   <= w_quo_chain[DIV_STEPS_PER_CYCLE];
                    r_count <= (r_count == LAST_COUNT) ? 5'd0 : r_count + 5'd1;
                end
                FIXUP: begin
                    r_hi   <= w_rem_fix;
                    r_lo   <= r_div_zero ? DIV_BY_ZERO_LO : w_quo_fix;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_busy  = r_busy;
    assign o_done  = r_done;
    assign o_hi    = r_hi;
    assign o_lo    = r_lo;
    assign o_state = r_state;

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Self-checking bench for mips_cpu_muldiv (1 and 4 quotient bits per cycle).
module tb_mips_cpu_muldiv;
    import mips_cpu_pkg::*;

    localparam int DIV_LAT1 = 33;
    localparam int DIV_LAT4 = 9;

    // Clock / reset and stimulus signals
    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          clk_enable = 1'b1;
    logic          start = 1'b0;
    muldiv_op_t    op = OP_MULT;
    logic [31:0]   a = 32'd0;
    logic [31:0]   b = 32'd0;
    logic          busy, done;
    logic [31:0]   hi, lo;
    muldiv_state_t st;

    logic          start4 = 1'b0;
    muldiv_op_t    op4 = OP_MULT;
    logic [31:0]   a4 = 32'd0;
    logic [31:0]   b4 = 32'd0;
    logic          busy4, done4;
    logic [31:0]   hi4, lo4;
    muldiv_state_t st4;

    int            n_tests = 0;
    int            n_fail = 0;
    logic [63:0]   exp_q[$];
    logic [31:0]   m_hi = 32'd0;
    logic [31:0]   m_lo = 32'd0;

    always #5 clk = ~clk;

    mips_cpu_muldiv #(.DIV_STEPS_PER_CYCLE(1)) dut (
        .i_clk(clk), .i_reset(reset), .i_clk_enable(clk_enable), .i_start(start),
        .i_op(op), .i_operand_a(a), .i_operand_b(b),
        .o_busy(busy), .o_done(done), .o_hi(hi), .o_lo(lo), .o_state(st)
    );

    mips_cpu_muldiv #(.DIV_STEPS_PER_CYCLE(4)) dut4 (
        .i_clk(clk), .i_reset(reset), .i_clk_enable(1'b1), .i_start(start4),
        .i_op(op4), .i_operand_a(a4), .i_operand_b(b4),
        .o_busy(busy4), .o_done(done4), .o_hi(hi4), .o_lo(lo4), .o_state(st4)
    );

    // Reference model: {hi, lo} after an arithmetic op.
    function automatic logic [63:0] model(input muldiv_op_t o, input logic [31:0] x, input logic [31:0] y);
        longint      p;
        int          sx, sy, q, r;
        logic [63:0] res;
        res = 64'd0;
        case (o)
            OP_MULT: begin
                p = longint'($signed(x)) * longint'($signed(y));
                res = p;
            end
            OP_MULTU: res = {32'd0, x} * {32'd0, y};
            OP_DIV: begin
                if (y == 32'd0) res = {x, 32'hFFFF_FFFF};
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) res = {32'd0, 32'h8000_0000};
                else begin
                    sx = x; sy = y;
                    q = sx / sy; r = sx % sy;
                    res = {r, q};
                end
            end
            OP_DIVU: begin
                if (y == 32'd0) res = {x, 32'hFFFF_FFFF};
                else res = {x % y, x / y};
            end
            default: res = {m_hi, m_lo};
        endcase
        return res;
    endfunction

    // Driver: present one request for a single accepting edge.
    task automatic drive_start(input muldiv_op_t o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Bounded wait for done on the main DUT, counting busy cycles seen on the way.
    task automatic wait_done(input int max_cycles, inout int busy_cnt, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
            else if (busy === 1'b1) busy_cnt++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_tests++; if (hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", hi); end
        n_tests++; if (lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h want 0", lo); end
        n_tests++; if (st !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want IDLE", st); end
        reset = 1'b0;
    endtask

    task automatic test_mult();
        muldiv_op_t  t_op[6];
        logic [31:0] t_a[6];
        logic [31:0] t_b[6];
        logic [63:0] exp;
        int          bc;
        bit          seen;
        t_op[0] = OP_MULT;  t_a[0] = 32'hFFFF_FFFF; t_b[0] = 32'd2;
        t_op[1] = OP_MULTU; t_a[1] = 32'hFFFF_FFFF; t_b[1] = 32'd2;
        t_op[2] = OP_MULT;  t_a[2] = 32'h8000_0000; t_b[2] = 32'h8000_0000;
        t_op[3] = OP_MULTU; t_a[3] = 32'hFFFF_FFFF; t_b[3] = 32'hFFFF_FFFF;
        for (int i = 4; i < 6; i++) begin
            t_op[i] = (i == 4) ? OP_MULT : OP_MULTU;
            t_a[i]  = $urandom_range(32'hFFFF_FFFF, 0);
            t_b[i]  = $urandom_range(32'hFFFF_FFFF, 0);
        end
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(model(t_op[i], t_a[i], t_b[i]));
            drive_start(t_op[i], t_a[i], t_b[i]);
            bc = 0;
            wait_done(4, bc, seen);
            exp = exp_q.pop_front();
            {m_hi, m_lo} = exp;
            n_tests++; if (!seen) begin n_fail++; $display("FAIL mult%0d_done: no done pulse", i); end
            n_tests++; if (bc != 0) begin n_fail++; $display("FAIL mult%0d_busy: got %0d busy cycles want 0", i, bc); end
            n_tests++; if ({hi, lo} !== exp) begin n_fail++; $display("FAIL mult%0d_result: got %h_%h want %h_%h", i, hi, lo, exp[63:32], exp[31:0]); end
            @(negedge clk);
            n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL mult%0d_pulse: done got %b want 0", i, done); end
        end
    endtask

    task automatic test_move();
        drive_start(OP_MTHI, 32'hA5A5_5A5A, 32'd0);
        @(negedge clk);
        n_tests++; if (hi !== 32'hA5A5_5A5A) begin n_fail++; $display("FAIL mthi_hi: got %h want a5a55a5a", hi); end
        n_tests++; if (lo !== m_lo) begin n_fail++; $display("FAIL mthi_lo: got %h want %h", lo, m_lo); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL mthi_done: got %b want 0", done); end
        m_hi = 32'hA5A5_5A5A;
        drive_start(OP_MTLO, 32'h0BAD_BEEF, 32'd0);
        @(negedge clk);
        n_tests++; if (lo !== 32'h0BAD_BEEF) begin n_fail++; $display("FAIL mtlo_lo: got %h want 0badbeef", lo); end
        n_tests++; if (hi !== m_hi) begin n_fail++; $display("FAIL mtlo_hi: got %h want %h", hi, m_hi); end
        m_lo = 32'h0BAD_BEEF;
    endtask

    task automatic test_div();
        muldiv_op_t  t_op[9];
        logic [31:0] t_a[9];
        logic [31:0] t_b[9];
        logic [63:0] exp;
        int          bc;
        bit          seen;
        t_op[0] = OP_DIV;  t_a[0] = 32'hFFFF_FFF9; t_b[0] = 32'd2;
        t_op[1] = OP_DIVU; t_a[1] = 32'd100;       t_b[1] = 32'd7;
        t_op[2] = OP_DIVU; t_a[2] = 32'd5;         t_b[2] = 32'd0;
        t_op[3] = OP_DIV;  t_a[3] = 32'h8000_0000; t_b[3] = 32'hFFFF_FFFF;
        t_op[4] = OP_DIV;  t_a[4] = 32'hFFFF_FF00; t_b[4] = 32'd0;
        t_op[5] = OP_DIV;  t_a[5] = 32'd7;         t_b[5] = 32'hFFFF_FFFE;
        for (int i = 6; i < 9; i++) begin
            t_op[i] = (i == 7) ? OP_DIVU : OP_DIV;
            t_a[i]  = $urandom_range(32'hFFFF_FFFF, 0);
            t_b[i]  = $urandom_range(32'h0000_FFFF, 1);
        end
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back(model(t_op[i], t_a[i], t_b[i]));
            drive_start(t_op[i], t_a[i], t_b[i]);
            bc = 0;
            wait_done(60, bc, seen);
            exp = exp_q.pop_front();
            {m_hi, m_lo} = exp;
            n_tests++; if (!seen) begin n_fail++; $display("FAIL div%0d_done: no done pulse within 60 cycles", i); end
            n_tests++; if (bc != DIV_LAT1) begin n_fail++; $display("FAIL div%0d_busy: got %0d busy cycles want %0d", i, bc, DIV_LAT1); end
            n_tests++; if ({hi, lo} !== exp) begin n_fail++; $display("FAIL div%0d_result: got %h_%h want %h_%h", i, hi, lo, exp[63:32], exp[31:0]); end
            n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL div%0d_idle: busy got %b want 0", i, busy); end
        end
    endtask

    task automatic test_div4();
        logic [31:0] t_a[2];
        logic [31:0] t_b[2];
        muldiv_op_t  t_op[2];
        logic [63:0] exp;
        int          bc;
        bit          seen;
        t_op[0] = OP_DIV;  t_a[0] = 32'hFFFF_FFF9; t_b[0] = 32'd2;
        t_op[1] = OP_DIVU; t_a[1] = 32'd100;       t_b[1] = 32'd7;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(model(t_op[i], t_a[i], t_b[i]));
            @(negedge clk);
            start4 = 1'b1; op4 = t_op[i]; a4 = t_a[i]; b4 = t_b[i];
            @(posedge clk);
            #1;
            start4 = 1'b0;
            bc = 0; seen = 1'b0;
            for (int k = 0; k < 30 && !seen; k++) begin
                @(negedge clk);
                if (done4 === 1'b1) seen = 1'b1;
                else if (busy4 === 1'b1) bc++;
            end
            exp = exp_q.pop_front();
            n_tests++; if (!seen) begin n_fail++; $display("FAIL div4_%0d_done: no done pulse within 30 cycles", i); end
            n_tests++; if (bc != DIV_LAT4) begin n_fail++; $display("FAIL div4_%0d_busy: got %0d busy cycles want %0d", i, bc, DIV_LAT4); end
            n_tests++; if ({hi4, lo4} !== exp) begin n_fail++; $display("FAIL div4_%0d_result: got %h_%h want %h_%h", i, hi4, lo4, exp[63:32], exp[31:0]); end
        end
    endtask

    task automatic test_ignored_while_busy();
        logic [63:0] exp;
        int          bc;
        bit          seen;
        exp_q.push_back(model(OP_DIV, 32'd1000, 32'd3));
        drive_start(OP_DIV, 32'd1000, 32'd3);
        repeat (3) @(negedge clk);
        drive_start(OP_MTHI, 32'h0000_1234, 32'd0);
        @(negedge clk);
        n_tests++; if (hi !== m_hi) begin n_fail++; $display("FAIL busy_mthi_hi: got %h want %h", hi, m_hi); end
        drive_start(OP_MULT, 32'd5, 32'd6);
        @(negedge clk);
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL busy_mult_done: got %b want 0", done); end
        n_tests++; if ({hi, lo} !== {m_hi, m_lo}) begin n_fail++; $display("FAIL busy_hold: got %h_%h want %h_%h", hi, lo, m_hi, m_lo); end
        bc = 0;
        wait_done(60, bc, seen);
        exp = exp_q.pop_front();
        {m_hi, m_lo} = exp;
        n_tests++; if (!seen) begin n_fail++; $display("FAIL busy_div_done: no done pulse within 60 cycles"); end
        n_tests++; if ({hi, lo} !== exp) begin n_fail++; $display("FAIL busy_div_result: got %h_%h want %h_%h", hi, lo, exp[63:32], exp[31:0]); end
    endtask

    task automatic test_stall();
        logic [63:0] exp;
        int          bc;
        bit          seen;
        exp_q.push_back(model(OP_DIV, 32'hFFFF_FF00, 32'd7));
        drive_start(OP_DIV, 32'hFFFF_FF00, 32'd7);
        bc = 0;
        repeat (3) begin @(negedge clk); if (busy === 1'b1) bc++; end
        clk_enable = 1'b0;
        repeat (5) begin @(negedge clk); if (busy === 1'b1) bc++; end
        clk_enable = 1'b1;
        wait_done(60, bc, seen);
        exp = exp_q.pop_front();
        {m_hi, m_lo} = exp;
        n_tests++; if (!seen) begin n_fail++; $display("FAIL stall_done: no done pulse within bound"); end
        n_tests++; if (bc != DIV_LAT1 + 5) begin n_fail++; $display("FAIL stall_busy: got %0d busy cycles want %0d", bc, DIV_LAT1 + 5); end
        n_tests++; if ({hi, lo} !== exp) begin n_fail++; $display("FAIL stall_result: got %h_%h want %h_%h", hi, lo, exp[63:32], exp[31:0]); end
        // done must be held, not re-pulsed, across a stall
        exp_q.push_back(model(OP_MULT, 32'd3, 32'hFFFF_FFFC));
        drive_start(OP_MULT, 32'd3, 32'hFFFF_FFFC);
        @(negedge clk);
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL hold_done0: got %b want 1", done); end
        clk_enable = 1'b0;
        for (int k = 1; k < 3; k++) begin
            @(negedge clk);
            n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL hold_done%0d: got %b want 1", k, done); end
        end
        clk_enable = 1'b1;
        @(negedge clk);
        exp = exp_q.pop_front();
        {m_hi, m_lo} = exp;
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL hold_release: done got %b want 0", done); end
        n_tests++; if ({hi, lo} !== exp) begin n_fail++; $display("FAIL hold_result: got %h_%h want %h_%h", hi, lo, exp[63:32], exp[31:0]); end
    endtask

    task automatic test_async_reset();
        drive_start(OP_DIV, 32'h1234_5678, 32'd17);
        repeat (10) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL areset_busy: got %b want 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL areset_done: got %b want 0", done); end
        n_tests++; if (hi !== 32'd0) begin n_fail++; $display("FAIL areset_hi: got %h want 0", hi); end
        n_tests++; if (lo !== 32'd0) begin n_fail++; $display("FAIL areset_lo: got %h want 0", lo); end
        n_tests++; if (st !== IDLE) begin n_fail++; $display("FAIL areset_state: got %0d want IDLE", st); end
        @(negedge clk);
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        drive_start(OP_MTLO, 32'hCAFE_F00D, 32'd0);
        @(negedge clk);
        n_tests++; if (lo !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL areset_mtlo_lo: got %h want cafef00d", lo); end
        n_tests++; if (hi !== 32'd0) begin n_fail++; $display("FAIL areset_mtlo_hi: got %h want 0", hi); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL areset_mtlo_busy: got %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_move();
        test_div();
        test_div4();
        test_ignored_while_busy();
        test_stall();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
